in128_out1536: RTL and testbench

Width up-converter that packs a 128-bit AXI-Stream into 1536-bit words, twelve input beats per output word. It sits directly upstream of the 1536-to-128 down-converter in the data route and restores the wide word format consumed there. It also closes short words on `s_axis_tlast`, zero-pads the unused lanes and reports how many lanes are valid.

---
 rtl/in128_out1536_pkg.sv | 22 ++
 rtl/in128_out1536.sv | 157 +++++++++++++++
 tb/tb_in128_out1536.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/in128_out1536_pkg.sv
`default_nettype none
// ============================================================================
// Module   : in128_out1536_pkg
// Purpose  : Shared constants for the 128 <-> 1536 bit data-route width
//            converters (up-converter in128_out1536 and its downstream
//            down-converter partner).
// Contents : DATA_IN_W  - narrow beat width
//            RATIO      - narrow beats per wide word
//            DATA_OUT_W - wide word width
//            CNT_W      - lane counter / beat count width (2**CNT_W > RATIO)
// Revision : 1.0 - initial release
// ============================================================================
package in128_out1536_pkg;

  localparam int DATA_IN_W  = 128;
  localparam int RATIO      = 12;
  localparam int DATA_OUT_W = DATA_IN_W * RATIO;
  localparam int CNT_W      = 4;

endpackage : in128_out1536_pkg

`default_nettype wire

// File: rtl/in128_out1536.sv
`default_nettype none
// ============================================================================
// Module   : in128_out1536
// Purpose  : AXI-Stream width up-converter. Packs RATIO narrow beats into one
//            wide word (lane 0 = first beat = LSB). A beat with s_axis_tlast
//            closes a short word early; unused lanes are zero and
//            m_axis_tbeats reports how many lanes carry data.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            s_axis_tdata/tvalid/tlast/tready - narrow input stream
//            m_axis_tdata/tvalid/tlast/tready - wide output stream
//            m_axis_tbeats       - valid lanes in the output word (1..RATIO)
// Revision : 1.0 - initial release
// ============================================================================
module in128_out1536
  import in128_out1536_pkg::*;
#(
  parameter int DATA_IN_W = in128_out1536_pkg::DATA_IN_W,
  parameter int RATIO     = in128_out1536_pkg::RATIO,
  parameter int CNT_W     = in128_out1536_pkg::CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_IN_W-1:0]         s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [DATA_IN_W*RATIO-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic [CNT_W-1:0]             m_axis_tbeats,
  input  logic                         m_axis_tready
);

  localparam int OUT_W = DATA_IN_W * RATIO;

  // Writes beat into lane 'lane' of acc and forces every lane above it to
  // zero, so a short word never carries stale data in its unused lanes.
  function automatic logic [OUT_W-1:0] merge_lane(
    input logic [OUT_W-1:0]     acc,
    input logic [DATA_IN_W-1:0] beat,
    input logic [CNT_W-1:0]     lane
  );
    logic [OUT_W-1:0] w;
    w = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CNT_W'(i)) begin
        w[i*DATA_IN_W +: DATA_IN_W] = beat;
      end else if (CNT_W'(i) > lane) begin
        w[i*DATA_IN_W +: DATA_IN_W] = '0;
      end
    end
    return w;
  endfunction

  // Accumulator state
  logic [OUT_W-1:0] acc_q,        acc_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             closed_q,     closed_d;
  logic             cl_last_q,    cl_last_d;
  logic [CNT_W-1:0] cl_beats_q,   cl_beats_d;

  // Output register
  logic [OUT_W-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic             out_last_q,   out_last_d;
  logic [CNT_W-1:0] out_beats_q,  out_beats_d;

  logic             out_free;
  logic             accept;
  logic             closing;
  logic [OUT_W-1:0] merged;
  logic [CNT_W-1:0] beats_now;

  assign s_axis_tready = ~rst & ~closed_q;
  assign out_free      = ~out_valid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign closing       = accept & ((cnt_q == CNT_W'(RATIO - 1)) | s_axis_tlast);
  assign merged        = merge_lane(acc_q, s_axis_tdata, cnt_q);
  assign beats_now     = cnt_q + CNT_W'(1);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    closed_d    = closed_q;
    cl_last_d   = cl_last_q;
    cl_beats_d  = cl_beats_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_beats_d = out_beats_q;

    if (closed_q && out_free) begin
      // Drain the parked word; s_axis_tready is low so no beat competes.
      out_data_d  = acc_q;
      out_valid_d = 1'b1;
      out_last_d  = cl_last_q;
      out_beats_d = cl_beats_q;
      acc_d       = '0;
      cnt_d       = '0;
      closed_d    = 1'b0;
    end else begin
      if (out_valid_q && m_axis_tready) begin
        out_valid_d = 1'b0;
      end
      if (closing && out_free) begin
        // Bypass: the closing beat goes straight to the output register.
        out_data_d  = merged;
        out_valid_d = 1'b1;
        out_last_d  = s_axis_tlast;
        out_beats_d = beats_now;
        acc_d       = '0;
        cnt_d       = '0;
      end else if (closing) begin
        // Output busy: park the finished word and stop the input.
        acc_d       = merged;
        closed_d    = 1'b1;
        cl_last_d   = s_axis_tlast;
        cl_beats_d  = beats_now;
      end else if (accept) begin
        acc_d       = merged;
        cnt_d       = beats_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      closed_q    <= 1'b0;
      cl_last_q   <= 1'b0;
      cl_beats_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      closed_q    <= closed_d;
      cl_last_q   <= cl_last_d;
      cl_beats_q  <= cl_beats_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tbeats = out_beats_q;

endmodule : in128_out1536

`default_nettype wire

// File: tb/tb_in128_out1536.sv
`default_nettype none
// ============================================================================
// Module   : tb_in128_out1536
// Purpose  : Self-checking bench for in128_out1536. A reference model packs
//            accepted beats into expected words; observed output handshakes
//            are collected and compared word by word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_in128_out1536;

  localparam int IW = 128;
  localparam int NL = 12;
  localparam int OW = IW * NL;

  typedef struct {
    logic [OW-1:0] data;
    logic [3:0]    beats;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [3:0]    m_tbeats;
  logic          m_tready;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;

  logic [IW-1:0] part_q[$];
  word_t         exp_q[$];
  word_t         obs_q[$];

  in128_out1536 dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tbeats (m_tbeats),
    .m_axis_tready (m_tready)
  );

  always #5 clk = ~clk;

  // Reference model: a word is the list of accepted beats up to a tlast or
  // the RATIO-th beat, laid out lane 0 first, zero-filled above.
  function automatic void model_accept(input logic [IW-1:0] d, input logic l);
    word_t w;
    part_q.push_back(d);
    if (l || part_q.size() == NL) begin
      w.data = '0;
      foreach (part_q[i]) w.data = w.data | ({{(OW-IW){1'b0}}, part_q[i]} << (IW * i));
      w.beats = 4'(part_q.size());
      w.last  = l;
      exp_q.push_back(w);
      part_q.delete();
    end
  endfunction

  // Handshakes are evaluated mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    word_t o;
    if (!rst && s_tvalid && s_tready) model_accept(s_tdata, s_tlast);
    if (!rst && m_tvalid && m_tready) begin
      o.data = m_tdata; o.beats = m_tbeats; o.last = m_tlast;
      obs_q.push_back(o);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] pat(input int k);
    return {96'h0123456789ABCDEF00000000, 32'(k)};
  endfunction

  // Presents one beat and returns 1 time unit after the edge that took it.
  task automatic drive_beat(input logic [IW-1:0] d, input logic l);
    int waitc = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready) begin
      waitc++; stall_cycles++;
      if (waitc > 2000) begin
        checks++; errors++;
        $display("FAIL drive_timeout: s_tready=%0b required 1 within 2000 cycles", s_tready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for all expected words to appear, then compares them in order.
  task automatic scoreboard_flush(input string name);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 5000) begin tick(1); n++; end
    tick(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: observed %0d words required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].beats !== exp_q[i].beats ||
          obs_q[i].last !== exp_q[i].last) begin
        errors++;
        for (int k = 0; k < NL; k++)
          if (obs_q[i].data[k*IW +: IW] !== exp_q[i].data[k*IW +: IW]) begin
            $display("FAIL %s_word%0d lane%0d: got %h required %h", name, i, k,
                     obs_q[i].data[k*IW +: IW], exp_q[i].data[k*IW +: IW]);
            break;
          end
        $display("FAIL %s_word%0d side: got beats=%0d last=%0b required beats=%0d last=%0b",
                 name, i, obs_q[i].beats, obs_q[i].last, exp_q[i].beats, exp_q[i].last);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    tick(3);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %0b required 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %0b required 0", m_tlast); end
    checks++; if (m_tbeats !== 4'd0) begin errors++; $display("FAIL rst_tbeats: got %0d required 0", m_tbeats); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata: nonzero, required 0"); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_sready: got %0b required 0", s_tready); end
    rst = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_release_sready: got %0b required 1", s_tready); end
    tick(1);
  endtask

  task automatic test_full_words();
    m_tready = 1'b1; stall_cycles = 0;
    for (int k = 0; k < 24; k++) drive_beat(pat(k), 1'b0);
    tick(2);
    checks++; if (stall_cycles != 0) begin errors++; $display("FAIL full_sready: stalled %0d cycles required 0", stall_cycles); end
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL full_nwords: got %0d required 2", obs_q.size()); end
    else begin
      for (int k = 0; k < NL; k++)
        if (obs_q[0].data[k*IW +: IW] !== pat(k)) begin
          errors++; $display("FAIL full_lane%0d: got %h required %h", k, obs_q[0].data[k*IW +: IW], pat(k));
          break;
        end
    end
    scoreboard_flush("full");
  endtask

  task automatic test_short_word();
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) drive_beat(pat(100 + k), k == 4);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL short_latency: tvalid got %0b required 1", m_tvalid); end
    checks++; if (m_tbeats !== 4'd5 || m_tlast !== 1'b1) begin errors++; $display("FAIL short_side: got beats=%0d last=%0b required 5/1", m_tbeats, m_tlast); end
    checks++; if (m_tdata[OW-1:5*IW] !== '0) begin errors++; $display("FAIL short_pad: lanes 5..11 nonzero, required 0"); end
    m_tready = 1'b1;
    scoreboard_flush("short");
  endtask

  task automatic test_stall();
    logic [OW-1:0] held;
    m_tready = 1'b0;
    for (int k = 0; k < 12; k++) drive_beat(pat(200 + k), 1'b0);
    held = m_tdata;
    for (int k = 12; k < 24; k++) drive_beat(pat(200 + k), 1'b0);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_sready_drop: got %0b required 0", s_tready); end
    tick(5);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_sready_hold: got %0b required 0", s_tready); end
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== held || m_tbeats !== 4'd12) begin
      errors++; $display("FAIL stall_stable: tvalid=%0b beats=%0d lane0=%h required 1/12/%h", m_tvalid, m_tbeats, m_tdata[IW-1:0], pat(200));
    end
    m_tready = 1'b1;
    tick(1);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL stall_sready_rise: got %0b required 1", s_tready); end
    checks++; if (m_tdata[IW-1:0] !== pat(212)) begin errors++; $display("FAIL stall_drain: lane0 got %h required %h", m_tdata[IW-1:0], pat(212)); end
    scoreboard_flush("stall");
  endtask

  task automatic test_single_beat();
    logic [OW-1:0] w;
    m_tready = 1'b0;
    drive_beat(128'hA5, 1'b1);
    w = '0; w[7:0] = 8'hA5;
    checks++; if (m_tvalid !== 1'b1 || m_tbeats !== 4'd1 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL single_side: got valid=%0b beats=%0d last=%0b required 1/1/1", m_tvalid, m_tbeats, m_tlast);
    end
    checks++; if (m_tdata !== w) begin errors++; $display("FAIL single_data: lane0=%h required a5 and rest zero", m_tdata[IW-1:0]); end
    m_tready = 1'b1;
    scoreboard_flush("single");
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int gap = $urandom_range(0, 2);
          if (gap != 0) tick(gap);
          drive_beat({$urandom, $urandom, $urandom, $urandom}, (i == 999) || ($urandom_range(0, 7) == 0));
        end
        done = 1;
      end
      begin
        while (!done) begin
          m_tready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    m_tready = 1'b1;
    scoreboard_flush("random");
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) drive_beat(pat(300 + k), k == 2);
    for (int k = 0; k < 7; k++) drive_beat(pat(310 + k), 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midrst_sready: got %0b required 0", s_tready); end
    tick(1);
    checks++; if (m_tvalid !== 1'b0 || m_tbeats !== 4'd0) begin errors++; $display("FAIL midrst_out: valid=%0b beats=%0d required 0/0", m_tvalid, m_tbeats); end
    rst = 1'b0;
    part_q.delete(); exp_q.delete(); obs_q.delete();
    m_tready = 1'b1;
    for (int k = 0; k < 12; k++) drive_beat(pat(400 + k), 1'b0);
    scoreboard_flush("midrst");
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    test_reset();
    test_full_words();
    test_short_word();
    test_stall();
    test_single_beat();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_in128_out1536

`default_nettype wire
